// File: rtl/mult_share_arbiter.sv
// Round-robin scheduler that shares one repeated-addition multiplier among
// NUM_REQ requesters and returns each product (or a timeout error) to the
// granted requester.
//
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   req_valid_i/req_a_i/b_i   per-requester operand pairs (packed DATA_W lanes)
//   req_ready_o               one-hot pulse: operands of requester i captured
//   rsp_valid_o/data/err      one-hot response pulse, product, timeout flag
//   mul_start_o/mul_data_o    multiplier start pulse and operand stream (A then B)
//   mul_done_i/mul_result_i   multiplier completion and product
//   busy_o                    high whenever the scheduler is not idle
module mult_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int TIMEOUT = 32
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    output logic [NUM_REQ-1:0]        rsp_valid_o,
    output logic [2*DATA_W-1:0]       rsp_data_o,
    output logic                      rsp_err_o,
    output logic                      mul_start_o,
    output logic [DATA_W-1:0]         mul_data_o,
    input  logic                      mul_done_i,
    input  logic [2*DATA_W-1:0]       mul_result_i,
    output logic                      busy_o
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        WAIT,
        RESP
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [PW-1:0]       ptr;
    logic [PW-1:0]       gnt;
    logic [PW-1:0]       gnt_sel;
    logic                gnt_found;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [TW-1:0]       timer;
    logic [2*DATA_W-1:0] result;
    logic                err;
    logic                timeout;

    assign timeout = (timer == TW'(TIMEOUT - 1));

    // Search starts just after the last granted requester, so the most
    // recently served one has the lowest priority.
    always_comb begin
        gnt_sel   = '0;
        gnt_found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (!gnt_found && req_valid_i[(int'(ptr) + i) % NUM_REQ]) begin
                gnt_sel   = PW'((int'(ptr) + i) % NUM_REQ);
                gnt_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nxt;
    end

    // Completion is only honoured in WAIT, so a stale done from the
    // previous operation cannot finish the next one early.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:   if (gnt_found) state_nxt = LOAD_A;
            LOAD_A: state_nxt = LOAD_B;
            LOAD_B: state_nxt = WAIT;
            WAIT:   if (mul_done_i || timeout) state_nxt = RESP;
            RESP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ptr    <= PW'(NUM_REQ - 1);
            gnt    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            timer  <= '0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (gnt_found) begin
                        gnt <= gnt_sel;
                        a_q <= req_a_i[int'(gnt_sel)*DATA_W +: DATA_W];
                        b_q <= req_b_i[int'(gnt_sel)*DATA_W +: DATA_W];
                    end
                end
                LOAD_B: timer <= '0;
                WAIT: begin
                    timer <= timer + 1'b1;
                    if (mul_done_i) begin
                        result <= mul_result_i;
                        err    <= 1'b0;
                    end else if (timeout) begin
                        result <= '0;
                        err    <= 1'b1;
                    end
                end
                RESP: ptr <= gnt;
                default: ;
            endcase
        end
    end

    always_comb begin
        req_ready_o = '0;
        rsp_valid_o = '0;
        rsp_data_o  = '0;
        rsp_err_o   = 1'b0;
        mul_start_o = 1'b0;
        mul_data_o  = '0;
        busy_o      = (state != IDLE);
        unique case (state)
            LOAD_A: begin
                req_ready_o = NUM_REQ'(1) << gnt;
                mul_start_o = 1'b1;
                mul_data_o  = a_q;
            end
            LOAD_B: mul_data_o = b_q;
            RESP: begin
                rsp_valid_o = NUM_REQ'(1) << gnt;
                rsp_data_o  = result;
                rsp_err_o   = err;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed testbench for mult_share_arbiter with a cycle-level multiplier
// model driven from the stimulus process.
module tb_mult_share_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [3:0]  req_valid_i;
    logic [15:0] req_a_i;
    logic [15:0] req_b_i;
    logic [3:0]  req_ready_o;
    logic [3:0]  rsp_valid_o;
    logic [7:0]  rsp_data_o;
    logic        rsp_err_o;
    logic        mul_start_o;
    logic [3:0]  mul_data_o;
    logic        mul_done_i;
    logic [7:0]  mul_result_i;
    logic        busy_o;

    mult_share_arbiter #(.NUM_REQ(4), .DATA_W(4), .TIMEOUT(32)) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .req_valid_i (req_valid_i),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_ready_o (req_ready_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_err_o   (rsp_err_o),
        .mul_start_o (mul_start_o),
        .mul_data_o  (mul_data_o),
        .mul_done_i  (mul_done_i),
        .mul_result_i(mul_result_i),
        .busy_o      (busy_o)
    );

    always #5 clk_in = ~clk_in;

    int n_tests = 0;
    int n_fail  = 0;

    // multiplier model state
    int         m_delay = 6;
    bit         m_never = 0;
    bit         m_force = 0;
    int         m_cnt   = -1;
    logic [3:0] cap_a   = '0;
    logic [3:0] cap_b   = '0;

    // observed events
    int         rsp_cnt   = 0;
    int         ready_cnt = 0;
    int         waited    = 0;
    logic [3:0] last_ready = '0;
    logic [3:0] last_rsp_v = '0;
    logic [7:0] last_rsp_d = '0;
    logic       last_rsp_e = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample just after the edge, then update requesters and
    // the multiplier model for the coming cycle.
    task automatic tick();
        @(posedge clk_in);
        #1;
        if (req_ready_o != 0) begin
            last_ready  = req_ready_o;
            ready_cnt++;
            req_valid_i = req_valid_i & ~req_ready_o;
        end
        if (rsp_valid_o != 0) begin
            last_rsp_v = rsp_valid_o;
            last_rsp_d = rsp_data_o;
            last_rsp_e = rsp_err_o;
            rsp_cnt++;
        end
        mul_done_i   = m_force;
        mul_result_i = m_force ? 8'hEE : 8'h00;
        if (mul_start_o) begin
            cap_a = mul_data_o;
            m_cnt = 0;
        end else if (m_cnt >= 0) begin
            m_cnt++;
        end
        if (m_cnt == 1) cap_b = mul_data_o;
        if (!m_never && m_cnt == m_delay) begin
            mul_done_i   = 1'b1;
            mul_result_i = cap_a * cap_b;
            m_cnt        = -1;
        end
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int start;
        start  = rsp_cnt;
        waited = 0;
        while (rsp_cnt == start && waited < budget) begin
            tick();
            waited++;
        end
        chk(tag, 32'(rsp_cnt != start), 32'd1);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int start;
        int n;
        start = ready_cnt;
        n     = 0;
        while (ready_cnt == start && n < budget) begin
            tick();
            n++;
        end
        chk(tag, 32'(ready_cnt != start), 32'd1);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic set_req(input int i, input logic [3:0] a,
                           input logic [3:0] b);
        req_a_i[i*4 +: 4] = a;
        req_b_i[i*4 +: 4] = b;
        req_valid_i[i]    = 1'b1;
    endtask

    initial begin
        rst_in       = 1'b1;
        req_valid_i  = '0;
        req_a_i      = '0;
        req_b_i      = '0;
        mul_done_i   = 1'b0;
        mul_result_i = '0;
        do_reset();

        // reset state
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_ready", 32'(req_ready_o), 0);
        chk("rst_rspv", 32'(rsp_valid_o), 0);
        chk("rst_start", 32'(mul_start_o), 0);
        chk("rst_mdata", 32'(mul_data_o), 0);
        chk("rst_rdata", 32'(rsp_data_o), 0);

        // 1: single op 3x5, done 6 cycles after start
        set_req(0, 4'd3, 4'd5);
        tick();
        chk("t1_ready", 32'(req_ready_o), 32'h1);
        chk("t1_start", 32'(mul_start_o), 1);
        chk("t1_opa", 32'(mul_data_o), 3);
        chk("t1_busy", 32'(busy_o), 1);
        tick();
        chk("t1_opb", 32'(mul_data_o), 5);
        chk("t1_start_lo", 32'(mul_start_o), 0);
        wait_rsp("t1_rsp_seen", 20);
        chk("t1_latency", 32'(waited), 6);
        chk("t1_rspv", 32'(last_rsp_v), 32'h1);
        chk("t1_data", 32'(last_rsp_d), 15);
        chk("t1_err", 32'(last_rsp_e), 0);
        tick();
        chk("t1_idle", 32'(busy_o), 0);
        chk("t1_rdata0", 32'(rsp_data_o), 0);

        // 2: all four requesters at once, round-robin from req 0
        do_reset();
        for (int k = 0; k < 4; k++) set_req(k, 4'(k + 1), 4'(k + 1));
        for (int k = 0; k < 4; k++) begin
            wait_ready("t2_ready_seen", 20);
            chk("t2_grant", 32'(last_ready), 32'(1 << k));
            wait_rsp("t2_rsp_seen", 20);
            chk("t2_rspv", 32'(last_rsp_v), 32'(1 << k));
            chk("t2_data", 32'(last_rsp_d), 32'((k + 1) * (k + 1)));
        end

        // 3: boundary operands on req 2
        set_req(2, 4'd15, 4'd15);
        wait_ready("t3_ready_seen", 20);
        chk("t3_grant", 32'(last_ready), 32'h4);
        wait_rsp("t3_rsp_seen", 20);
        chk("t3_data_max", 32'(last_rsp_d), 225);
        chk("t3_err_max", 32'(last_rsp_e), 0);
        set_req(2, 4'd0, 4'd9);
        wait_rsp("t3_rsp0_seen", 30);
        chk("t3_rspv0", 32'(last_rsp_v), 32'h4);
        chk("t3_data_zero", 32'(last_rsp_d), 0);
        chk("t3_err_zero", 32'(last_rsp_e), 0);

        // 4: multiplier never completes -> timeout after 32 WAIT cycles
        m_never = 1;
        set_req(1, 4'd2, 4'd3);
        wait_ready("t4_ready_seen", 20);
        wait_rsp("t4_rsp_seen", 60);
        chk("t4_to_latency", 32'(waited), 34);
        chk("t4_rspv", 32'(last_rsp_v), 32'h2);
        chk("t4_data", 32'(last_rsp_d), 0);
        chk("t4_err", 32'(last_rsp_e), 1);
        tick();
        chk("t4_idle", 32'(busy_o), 0);
        m_never = 0;
        m_cnt   = -1;

        // 5: reset mid-WAIT aborts silently, pointer returns to req 0
        set_req(3, 4'd7, 4'd2);
        wait_ready("t5_ready_seen", 20);
        tick();
        tick();
        tick();
        chk("t5_busy_wait", 32'(busy_o), 1);
        begin
            int rc;
            rc = rsp_cnt;
            do_reset();
            for (int k = 0; k < 8; k++) tick();
            chk("t5_no_rsp", 32'(rsp_cnt), 32'(rc));
        end
        chk("t5_busy", 32'(busy_o), 0);
        chk("t5_ready", 32'(req_ready_o), 0);
        chk("t5_rspv", 32'(rsp_valid_o), 0);
        chk("t5_mdata", 32'(mul_data_o), 0);
        set_req(0, 4'd6, 4'd7);
        set_req(2, 4'd5, 4'd3);
        wait_ready("t5_ready2_seen", 20);
        chk("t5_grant0", 32'(last_ready), 32'h1);
        wait_rsp("t5_rsp0_seen", 20);
        chk("t5_data0", 32'(last_rsp_d), 42);
        wait_rsp("t5_rsp2_seen", 30);
        chk("t5_rspv2", 32'(last_rsp_v), 32'h4);
        chk("t5_data2", 32'(last_rsp_d), 15);

        // 6: done held high through LOAD_A/LOAD_B is ignored
        m_force = 1;
        mul_done_i   = 1'b1;
        mul_result_i = 8'hEE;
        set_req(1, 4'd4, 4'd4);
        wait_ready("t6_ready_seen", 20);
        chk("t6_grant", 32'(last_ready), 32'h2);
        tick();
        chk("t6_loadb", 32'(mul_data_o), 4);
        m_force = 0;
        begin
            int rc;
            rc = rsp_cnt;
            tick();
            chk("t6_no_early", 32'(rsp_cnt), 32'(rc));
        end
        wait_rsp("t6_rsp_seen", 20);
        chk("t6_latency", 32'(waited), 5);
        chk("t6_data", 32'(last_rsp_d), 16);
        chk("t6_err", 32'(last_rsp_e), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
